// File: rtl/pa_spsram_pkg.sv
// Shared definitions for the parametrised single-port SRAM wrapper.
// Holds the controller FSM encoding and the elaboration-time helpers that
// derive depth and write-group width from the instance parameters.
package pa_spsram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Number of entries for a given address width.
    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Bits covered by one write-enable group.
    function automatic int gw_of(input int data_width, input int we_width);
        return data_width / we_width;
    endfunction

    // Write groups must tile the data word exactly.
    function automatic bit we_width_ok(input int data_width, input int we_width);
        return (we_width > 0) && ((data_width % we_width) == 0);
    endfunction

endpackage

// File: rtl/pa_f_spsram_gen.sv
// Plain behavioural single-port array, no reset.
// Ports (all control active low):
//   CLK  - clock
//   A    - address
//   CEN  - chip enable
//   GWEN - global write enable (0 = write, 1 = read)
//   WEN  - per-group write enable, WEN[g] covers D[g*GW +: GW]
//   D    - write data
//   Q    - read data, one cycle after the read, held otherwise
module pa_f_spsram_gen
    import pa_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int WE_WIDTH   = 4
) (
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  CLK,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  GWEN,
    input  logic [WE_WIDTH-1:0]   WEN,
    output logic [DATA_WIDTH-1:0] Q
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int GW    = gw_of(DATA_WIDTH, WE_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (GWEN) begin
                Q <= mem[A];
            end else begin
                for (int g = 0; g < WE_WIDTH; g++) begin
                    if (!WEN[g]) begin
                        mem[A][g*GW +: GW] <= D[g*GW +: GW];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pa_spsram_gen.sv
// Parametrised single-port SRAM wrapper with post-reset clear sweep.
// Ports:
//   CLK  - clock, all state on rising edge
//   RST  - synchronous active-high reset
//   A    - access address
//   CEN  - chip enable, active low
//   GWEN - global write enable, active low (0 = write, 1 = read)
//   WEN  - per-group write enable, active low
//   D    - write data
//   Q    - read data, holds the last read value
//   QVLD - one-cycle strobe when Q carries fresh read data
//   BUSY - clear sweep in progress, requests are ignored
module pa_spsram_gen
    import pa_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int WE_WIDTH   = 4,
    parameter bit OUT_REG    = 1'b0,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  QVLD,
    output logic                  BUSY
);

    localparam int                  DEPTH    = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

    if (!we_width_ok(DATA_WIDTH, WE_WIDTH)) begin : g_bad_we_width
        $error("pa_spsram_gen: DATA_WIDTH must be a multiple of WE_WIDTH");
    end

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

    logic [ADDR_WIDTH-1:0] arr_a;
    logic                  arr_cen;
    logic                  arr_gwen;
    logic [WE_WIDTH-1:0]   arr_wen;
    logic [DATA_WIDTH-1:0] arr_d;
    logic [DATA_WIDTH-1:0] arr_q;

    logic                  rd_p0;
    logic                  vld_p1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= INIT_EN ? ST_INIT : ST_READY;
            cnt    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            vld_p1 <= rd_p0;
        end
    end

    // During the sweep the array sees the counter address, zero data and
    // all groups enabled; external requests never reach it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        arr_a     = A;
        arr_cen   = CEN;
        arr_gwen  = GWEN;
        arr_wen   = WEN;
        arr_d     = D;
        case (state)
            ST_INIT: begin
                arr_a    = cnt;
                arr_cen  = 1'b0;
                arr_gwen = 1'b0;
                arr_wen  = '0;
                arr_d    = '0;
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_READY;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
            end
        endcase
        // Nothing touches the array while reset is held.
        if (RST) begin
            arr_cen = 1'b1;
        end
    end

    // Stage 0: request accepted
    assign rd_p0 = (state == ST_READY) && !CEN && GWEN;
    assign BUSY  = (state == ST_INIT);

    pa_f_spsram_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WE_WIDTH   (WE_WIDTH)
    ) u_array (
        .A    (arr_a),
        .CEN  (arr_cen),
        .CLK  (CLK),
        .D    (arr_d),
        .GWEN (arr_gwen),
        .WEN  (arr_wen),
        .Q    (arr_q)
    );

    // Stage 1: array data returns alongside vld_p1
    if (OUT_REG) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_p2;
        logic                  vld_p2;

        // Stage 2: registered output; a reset here drops the read in flight
        always_ff @(posedge CLK) begin
            if (RST) begin
                q_p2   <= '0;
                vld_p2 <= 1'b0;
            end else begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    q_p2 <= arr_q;
                end
            end
        end

        assign Q    = q_p2;
        assign QVLD = vld_p2;
    end else begin : g_out_comb
        // The array output is unreset, so a held copy supplies Q=0 after
        // reset and shields Q from any array activity outside read returns.
        logic [DATA_WIDTH-1:0] q_hold_p1;

        always_ff @(posedge CLK) begin
            if (RST) begin
                q_hold_p1 <= '0;
            end else if (vld_p1) begin
                q_hold_p1 <= arr_q;
            end
        end

        assign Q    = vld_p1 ? arr_q : q_hold_p1;
        assign QVLD = vld_p1;
    end

endmodule
